// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the "0110" detector chain.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } ser_state_e;

  localparam int   DEFAULT_WIDTH  = 8;
  localparam logic IDLE_LEVEL_DEF = 1'b1;

endpackage

// File: rtl/seq_serializer_if.sv
// Parallel word handshake into the serializer.
interface seq_serializer_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder for the "0110" detector, zero-gap back-to-back streaming.
// Build option SEQ_SERIALIZER_PARITY_EN appends an even-parity bit after each word.
module seq_serializer
  import seq_det_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic            clk,
  input  logic            reset,
  seq_serializer_if.slave s,
  input  logic            abort,
  output logic            x_out,
  output logic            bit_valid,
  output logic            word_done
);

  localparam int               CNT_W      = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PENULT_IDX = CNT_W'(WIDTH - 2);

`ifdef SEQ_SERIALIZER_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
  logic par, par_n;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  ser_state_e       state, state_n;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             x_n, bit_valid_n, word_done_n;
  logic             ready, accept;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Ready opens on the final bit of a word so the next word follows with no gap.
  always_comb begin
    ready = 1'b0;
    if (!abort) begin
      case (state)
        ST_IDLE:   ready = 1'b1;
        ST_SHIFT:  ready = !PARITY_ON && (bit_cnt == LAST_IDX);
        ST_PARITY: ready = PARITY_ON;
        default:   ready = 1'b0;
      endcase
    end
  end

  assign s.s_ready = ready;
  assign accept    = s.s_valid && ready;

  // The shift register holds the bits still to be sent; x_out already carries the current one.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    x_n         = x_out;
    bit_valid_n = bit_valid;
    word_done_n = 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
    par_n       = par;
`endif
    if (abort) begin
      state_n     = ST_IDLE;
      bit_cnt_n   = '0;
      x_n         = IDLE_LEVEL;
      bit_valid_n = 1'b0;
    end else if (accept) begin
      state_n     = ST_SHIFT;
      bit_cnt_n   = '0;
      shreg_n     = shift_once(s.s_data);
      x_n         = head_bit(s.s_data);
      bit_valid_n = 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
      par_n       = ^s.s_data;
`endif
    end else begin
      case (state)
        ST_SHIFT: begin
          if (bit_cnt == LAST_IDX) begin
`ifdef SEQ_SERIALIZER_PARITY_EN
            state_n     = ST_PARITY;
            bit_cnt_n   = '0;
            x_n         = par;
            bit_valid_n = 1'b1;
            word_done_n = 1'b1;
`else
            state_n     = ST_IDLE;
            bit_cnt_n   = '0;
            x_n         = IDLE_LEVEL;
            bit_valid_n = 1'b0;
`endif
          end else begin
            bit_cnt_n   = bit_cnt + CNT_W'(1);
            shreg_n     = shift_once(shreg);
            x_n         = head_bit(shreg);
            bit_valid_n = 1'b1;
            word_done_n = !PARITY_ON && (bit_cnt == PENULT_IDX);
          end
        end
        default: begin
          state_n     = ST_IDLE;
          bit_cnt_n   = '0;
          x_n         = IDLE_LEVEL;
          bit_valid_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      x_out     <= IDLE_LEVEL;
      bit_valid <= 1'b0;
      word_done <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      x_out     <= x_n;
      bit_valid <= bit_valid_n;
      word_done <= word_done_n;
`ifdef SEQ_SERIALIZER_PARITY_EN
      par       <= par_n;
`endif
    end
  end

endmodule
